// File: rtl/jt900h_bankrf_pkg.sv
// jt900h_bankrf_pkg
// Shared definitions for the JT900H banked register file:
//   - access size encodings (byte / word / long)
//   - context engine state enum
//   - lane extract / merge helpers for 32-bit registers
package jt900h_bankrf_pkg;

   localparam logic [1:0] SZ_B = 2'd0;
   localparam logic [1:0] SZ_W = 2'd1;
   localparam logic [1:0] SZ_L = 2'd2;

   typedef enum logic [1:0] {
      CTX_IDLE,
      CTX_SAVE,
      CTX_RESTORE
   } ctx_state_t;

   // Pull the addressed byte or word out of a register, zero-extended.
   // Word accesses only look at lane[1]; longs ignore the lane entirely.
   // The unused size code 3 behaves as a long.
   function automatic logic [31:0] rf_extract(input logic [31:0] w,
                                              input logic [1:0]  size,
                                              input logic [1:0]  lane);
      logic [31:0] r;
      r = w;
      case (size)
         SZ_B:    r = {24'd0, w[{lane, 3'b000} +: 8]};
         SZ_W:    r = lane[1] ? {16'd0, w[31:16]} : {16'd0, w[15:0]};
         default: r = w;
      endcase
      return r;
   endfunction

   // Merge write data (right-aligned in din) into the addressed lane of old.
   function automatic logic [31:0] rf_merge(input logic [31:0] old,
                                            input logic [31:0] din,
                                            input logic [1:0]  size,
                                            input logic [1:0]  lane);
      logic [31:0] r;
      r = old;
      case (size)
         SZ_B: r[{lane, 3'b000} +: 8] = din[7:0];
         SZ_W: begin
            if (lane[1]) r[31:16] = din[15:0];
            else         r[15:0]  = din[15:0];
         end
         default: r = din;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/jt900h_bankrf_ctx.sv
// jt900h_bankrf_ctx
// Context engine: streams one bank out (save) or in (restore) over
// valid/ready handshakes, one register per accepted beat.
// Ports:
//   clk, rst_n, cen              clock, async active-low reset, clock enable
//   ctx_save, ctx_restore        start pulses (save wins if both)
//   ctx_bank                     target bank, latched at start
//   look_bank, look_idx, save_word  lookup of the next register to stream out
//   so_valid, so_ready, so_data  save stream
//   si_valid, si_ready           restore stream handshake
//   rest_we, rest_bank, rest_idx restore write strobe/address into the array
//   ctx_busy, ctx_done           status; done is a one-cen-cycle pulse
module jt900h_bankrf_ctx
   import jt900h_bankrf_pkg::*;
#(
   parameter int DW    = 32,
   parameter int BANKS = 4,
   parameter int REGS  = 4
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     cen,
   input  logic                     ctx_save,
   input  logic                     ctx_restore,
   input  logic [$clog2(BANKS)-1:0] ctx_bank,
   output logic [$clog2(BANKS)-1:0] look_bank,
   output logic [$clog2(REGS)-1:0]  look_idx,
   input  logic [DW-1:0]            save_word,
   output logic                     so_valid,
   input  logic                     so_ready,
   output logic [DW-1:0]            so_data,
   input  logic                     si_valid,
   output logic                     si_ready,
   output logic                     rest_we,
   output logic [$clog2(BANKS)-1:0] rest_bank,
   output logic [$clog2(REGS)-1:0]  rest_idx,
   output logic                     ctx_busy,
   output logic                     ctx_done
);

   localparam int BW = $clog2(BANKS);
   localparam int RW = $clog2(REGS);
   localparam logic [RW-1:0] LAST = RW'(REGS - 1);

   ctx_state_t    state;
   logic [BW-1:0] bank_q;
   logic [RW-1:0] idx_q;

   // so_data is loaded either at start (register 0 of the requested bank)
   // or on a handshake (the following register), so the lookup address
   // always points at whatever the next load will need.
   always_comb begin
      look_bank = bank_q;
      look_idx  = idx_q + 1'b1;
      if (state == CTX_IDLE) begin
         look_bank = ctx_bank;
         look_idx  = '0;
      end
   end

   assign rest_we   = cen && (state == CTX_RESTORE) && si_ready && si_valid;
   assign rest_bank = bank_q;
   assign rest_idx  = idx_q;

   // Engine FSM with registered stream/status outputs. Everything holds
   // while cen is low, so handshakes only count on enabled cycles.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= CTX_IDLE;
         bank_q   <= '0;
         idx_q    <= '0;
         so_valid <= 1'b0;
         so_data  <= '0;
         si_ready <= 1'b0;
         ctx_busy <= 1'b0;
         ctx_done <= 1'b0;
      end else if (cen) begin
         ctx_done <= 1'b0;
         case (state)
            CTX_IDLE: begin
               if (ctx_save) begin
                  state    <= CTX_SAVE;
                  bank_q   <= ctx_bank;
                  idx_q    <= '0;
                  ctx_busy <= 1'b1;
                  so_valid <= 1'b1;
                  so_data  <= save_word;
               end else if (ctx_restore) begin
                  state    <= CTX_RESTORE;
                  bank_q   <= ctx_bank;
                  idx_q    <= '0;
                  ctx_busy <= 1'b1;
                  si_ready <= 1'b1;
               end
            end
            CTX_SAVE: begin
               if (so_ready) begin
                  if (idx_q == LAST) begin
                     state    <= CTX_IDLE;
                     so_valid <= 1'b0;
                     ctx_busy <= 1'b0;
                     ctx_done <= 1'b1;
                  end else begin
                     idx_q   <= idx_q + 1'b1;
                     so_data <= save_word;
                  end
               end
            end
            CTX_RESTORE: begin
               if (si_valid) begin
                  if (idx_q == LAST) begin
                     state    <= CTX_IDLE;
                     si_ready <= 1'b0;
                     ctx_busy <= 1'b0;
                     ctx_done <= 1'b1;
                  end else begin
                     idx_q <= idx_q + 1'b1;
                  end
               end
            end
            default: state <= CTX_IDLE;
         endcase
      end
   end

endmodule

// File: rtl/jt900h_bankrf.sv
// jt900h_bankrf
// Banked register file: BANKS x REGS general registers addressed relative
// to the bank pointer rfp, plus PTRS global pointer registers. RDP
// combinational read ports, one byte/word/long write port, and a context
// engine for bank save/restore.
// Ports:
//   clk, rst_n, cen          clock, async active-low reset, clock enable
//   rfp, rfp_ld, rfp_din     bank pointer and its load
//   rd_addr, rd_size, rd_data  packed read ports, {ptr, index, lane}
//   we, wr_addr, wr_size, wr_data  write port
//   ctx_*, so_*, si_*        context engine control and streams
module jt900h_bankrf
   import jt900h_bankrf_pkg::*;
#(
   parameter  int DW    = 32,
   parameter  int BANKS = 4,
   parameter  int REGS  = 4,
   parameter  int PTRS  = 4,
   parameter  int RDP   = 2,
   localparam int AW    = 1 + $clog2(BANKS*REGS) + 2
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     cen,
   output logic [$clog2(BANKS)-1:0] rfp,
   input  logic                     rfp_ld,
   input  logic [$clog2(BANKS)-1:0] rfp_din,
   input  logic [RDP*AW-1:0]        rd_addr,
   input  logic [RDP*2-1:0]         rd_size,
   output logic [RDP*DW-1:0]        rd_data,
   input  logic                     we,
   input  logic [AW-1:0]            wr_addr,
   input  logic [1:0]               wr_size,
   input  logic [DW-1:0]            wr_data,
   input  logic                     ctx_save,
   input  logic                     ctx_restore,
   input  logic [$clog2(BANKS)-1:0] ctx_bank,
   output logic                     so_valid,
   input  logic                     so_ready,
   output logic [DW-1:0]            so_data,
   input  logic                     si_valid,
   output logic                     si_ready,
   input  logic [DW-1:0]            si_data,
   output logic                     ctx_busy,
   output logic                     ctx_done
);

   localparam int BW = $clog2(BANKS);
   localparam int RW = $clog2(REGS);
   localparam int IW = $clog2(BANKS*REGS);
   localparam int PW = $clog2(PTRS);
   localparam int NR = BANKS * REGS;

   logic [DW-1:0] regs_q [NR];
   logic [DW-1:0] ptr_q  [PTRS];

   logic [BW-1:0] look_bank;
   logic [RW-1:0] look_idx;
   logic [DW-1:0] save_word;
   logic          rest_we;
   logic [BW-1:0] rest_bank;
   logic [RW-1:0] rest_idx;
   logic [IW-1:0] rest_phys;

   // Bank-relative indices are offset by rfp*REGS and wrap around the
   // whole array, so a large index reaches into the following banks.
   logic [IW-1:0] bank_base;
   assign bank_base = {rfp, {RW{1'b0}}};

   // Read ports: pure muxing, no latency.
   for (genvar g = 0; g < RDP; g++) begin : g_rd
      logic [AW-1:0] a;
      logic [IW-1:0] ix;
      logic [IW-1:0] phys;
      logic [DW-1:0] word;
      assign a    = rd_addr[g*AW +: AW];
      assign ix   = a[AW-2:2];
      assign phys = bank_base + ix;
      assign word = a[AW-1] ? ptr_q[ix[PW-1:0]] : regs_q[phys];
      assign rd_data[g*DW +: DW] = rf_extract(word, rd_size[g*2 +: 2], a[1:0]);
   end

   logic          wr_ptr;
   logic [IW-1:0] wr_ix;
   logic [IW-1:0] wr_phys;
   assign wr_ptr  = wr_addr[AW-1];
   assign wr_ix   = wr_addr[AW-2:2];
   assign wr_phys = bank_base + wr_ix;

   assign save_word = regs_q[{look_bank, look_idx}];
   assign rest_phys = {rest_bank, rest_idx};

   // Storage and bank pointer. A restore beat owns its register for that
   // cycle: a core write to the same general register is dropped, while
   // core writes elsewhere (including pointers) go through.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rfp <= '0;
         for (int i = 0; i < NR; i++)   regs_q[i] <= '0;
         for (int i = 0; i < PTRS; i++) ptr_q[i]  <= '0;
      end else if (cen) begin
         if (rfp_ld) rfp <= rfp_din;
         if (we) begin
            if (wr_ptr)
               ptr_q[wr_ix[PW-1:0]] <= rf_merge(ptr_q[wr_ix[PW-1:0]], wr_data, wr_size, wr_addr[1:0]);
            else if (!(rest_we && (rest_phys == wr_phys)))
               regs_q[wr_phys] <= rf_merge(regs_q[wr_phys], wr_data, wr_size, wr_addr[1:0]);
         end
         if (rest_we) regs_q[rest_phys] <= si_data;
      end
   end

   jt900h_bankrf_ctx #(
      .DW    (DW),
      .BANKS (BANKS),
      .REGS  (REGS)
   ) u_ctx (
      .clk         (clk),
      .rst_n       (rst_n),
      .cen         (cen),
      .ctx_save    (ctx_save),
      .ctx_restore (ctx_restore),
      .ctx_bank    (ctx_bank),
      .look_bank   (look_bank),
      .look_idx    (look_idx),
      .save_word   (save_word),
      .so_valid    (so_valid),
      .so_ready    (so_ready),
      .so_data     (so_data),
      .si_valid    (si_valid),
      .si_ready    (si_ready),
      .rest_we     (rest_we),
      .rest_bank   (rest_bank),
      .rest_idx    (rest_idx),
      .ctx_busy    (ctx_busy),
      .ctx_done    (ctx_done)
   );

endmodule

// File: tb/tb_jt900h_bankrf.sv
// tb_jt900h_bankrf
// Directed bench for jt900h_bankrf with default parameters
// (4 banks x 4 regs, 4 pointers, 2 read ports, AW = 7).
module tb_jt900h_bankrf;

   localparam logic [1:0] B = 2'd0;
   localparam logic [1:0] W = 2'd1;
   localparam logic [1:0] L = 2'd2;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        cen;
   logic [1:0]  rfp;
   logic        rfp_ld;
   logic [1:0]  rfp_din;
   logic [13:0] rd_addr;
   logic [3:0]  rd_size;
   logic [63:0] rd_data;
   logic        we;
   logic [6:0]  wr_addr;
   logic [1:0]  wr_size;
   logic [31:0] wr_data;
   logic        ctx_save, ctx_restore;
   logic [1:0]  ctx_bank;
   logic        so_valid, so_ready;
   logic [31:0] so_data;
   logic        si_valid, si_ready;
   logic [31:0] si_data;
   logic        ctx_busy, ctx_done;

   logic [6:0]  ra0, ra1;
   logic [1:0]  sz0, sz1;
   logic [31:0] rd0, rd1;

   int n_checks = 0;
   int n_fail   = 0;

   assign rd_addr = {ra1, ra0};
   assign rd_size = {sz1, sz0};
   assign rd0     = rd_data[31:0];
   assign rd1     = rd_data[63:32];

   always #5 clk = ~clk;

   jt900h_bankrf dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .cen         (cen),
      .rfp         (rfp),
      .rfp_ld      (rfp_ld),
      .rfp_din     (rfp_din),
      .rd_addr     (rd_addr),
      .rd_size     (rd_size),
      .rd_data     (rd_data),
      .we          (we),
      .wr_addr     (wr_addr),
      .wr_size     (wr_size),
      .wr_data     (wr_data),
      .ctx_save    (ctx_save),
      .ctx_restore (ctx_restore),
      .ctx_bank    (ctx_bank),
      .so_valid    (so_valid),
      .so_ready    (so_ready),
      .so_data     (so_data),
      .si_valid    (si_valid),
      .si_ready    (si_ready),
      .si_data     (si_data),
      .ctx_busy    (ctx_busy),
      .ctx_done    (ctx_done)
   );

   function automatic logic [6:0] mk(input logic p, input logic [3:0] ix, input logic [1:0] ln);
      return {p, ix, ln};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_write(input logic [6:0] a, input logic [1:0] s, input logic [31:0] d);
      we = 1'b1; wr_addr = a; wr_size = s; wr_data = d;
      tick();
      we = 1'b0;
   endtask

   task automatic test_reset();
      ra0 = mk(0, 4'd0, 2'd0); sz0 = L;
      ra1 = mk(1, 4'd3, 2'd0); sz1 = L;
      #1;
      n_checks++; if (rd0 !== 32'd0) begin n_fail++; $display("[TB] FAIL reset_reg0 got %h want 0", rd0); end
      n_checks++; if (rd1 !== 32'd0) begin n_fail++; $display("[TB] FAIL reset_ptr3 got %h want 0", rd1); end
      n_checks++; if (rfp !== 2'd0) begin n_fail++; $display("[TB] FAIL reset_rfp got %h want 0", rfp); end
      n_checks++; if ({so_valid, si_ready, ctx_busy, ctx_done} !== 4'b0) begin n_fail++; $display("[TB] FAIL reset_status got %b want 0000", {so_valid, si_ready, ctx_busy, ctx_done}); end
      n_checks++; if (so_data !== 32'd0) begin n_fail++; $display("[TB] FAIL reset_so_data got %h want 0", so_data); end
   endtask

   task automatic test_lanes();
      do_write(mk(0, 4'd1, 2'd0), L, 32'h11223344);
      ra0 = mk(0, 4'd1, 2'd2); sz0 = B;
      ra1 = mk(0, 4'd1, 2'd2); sz1 = W;
      #1;
      n_checks++; if (rd0 !== 32'h22) begin n_fail++; $display("[TB] FAIL byte_lane2 got %h want 22", rd0); end
      n_checks++; if (rd1 !== 32'h1122) begin n_fail++; $display("[TB] FAIL word_lane2 got %h want 1122", rd1); end
      ra0 = mk(0, 4'd1, 2'd3); sz0 = L;
      #1;
      n_checks++; if (rd0 !== 32'h11223344) begin n_fail++; $display("[TB] FAIL long_read got %h want 11223344", rd0); end
      do_write(mk(0, 4'd1, 2'd3), B, 32'hFFFFFF99);
      do_write(mk(0, 4'd1, 2'd1), W, 32'hFFFFBEEF);
      ra1 = mk(0, 4'd1, 2'd0); sz1 = B;
      #1;
      n_checks++; if (rd0 !== 32'h9922BEEF) begin n_fail++; $display("[TB] FAIL partial_writes got %h want 9922beef", rd0); end
      n_checks++; if (rd1 !== 32'hEF) begin n_fail++; $display("[TB] FAIL byte_lane0 got %h want ef", rd1); end
   endtask

   task automatic test_bank_switch();
      do_write(mk(0, 4'd0, 2'd0), L, 32'h100);
      do_write(mk(0, 4'd4, 2'd0), L, 32'h101);
      do_write(mk(1, 4'd0, 2'd0), L, 32'h500);
      ra0 = mk(0, 4'd0, 2'd0); sz0 = L;
      ra1 = mk(1, 4'd0, 2'd0); sz1 = L;
      rfp_ld = 1'b1; rfp_din = 2'd1;
      #1;
      n_checks++; if (rd0 !== 32'h100) begin n_fail++; $display("[TB] FAIL rfp_old_read got %h want 100", rd0); end
      tick();
      rfp_ld = 1'b0;
      #1;
      n_checks++; if (rfp !== 2'd1) begin n_fail++; $display("[TB] FAIL rfp_loaded got %h want 1", rfp); end
      n_checks++; if (rd0 !== 32'h101) begin n_fail++; $display("[TB] FAIL rfp_new_read got %h want 101", rd0); end
      n_checks++; if (rd1 !== 32'h500) begin n_fail++; $display("[TB] FAIL ptr_unchanged got %h want 500", rd1); end
      rfp_ld = 1'b1; rfp_din = 2'd0;
      tick();
      rfp_ld = 1'b0;
   endtask

   task automatic test_save_toggle();
      int n = 0;
      int dones = 0;
      for (int k = 0; k < 4; k++) do_write(mk(0, 4'(8 + k), 2'd0), L, 32'hA0 + k);
      ctx_bank = 2'd2; ctx_save = 1'b1; so_ready = 1'b0;
      tick();
      ctx_save = 1'b0;
      #1;
      n_checks++; if ({ctx_busy, so_valid} !== 2'b11) begin n_fail++; $display("[TB] FAIL save_start got %b want 11", {ctx_busy, so_valid}); end
      for (int cyc = 0; cyc < 20; cyc++) begin
         so_ready = (cyc % 2 == 0);
         #1;
         if (so_valid && so_ready) begin
            n_checks++;
            if (n >= 4 || so_data !== 32'hA0 + n) begin n_fail++; $display("[TB] FAIL save_stream beat %0d got %h want %h", n, so_data, 32'hA0 + n); end
            n++;
         end
         if (ctx_done) begin
            dones++;
            n_checks++; if (ctx_busy !== 1'b0) begin n_fail++; $display("[TB] FAIL save_busy_at_done got %b want 0", ctx_busy); end
         end
         tick();
      end
      so_ready = 1'b0;
      n_checks++; if (n !== 4) begin n_fail++; $display("[TB] FAIL save_beats got %0d want 4", n); end
      n_checks++; if (dones !== 1) begin n_fail++; $display("[TB] FAIL save_done_count got %0d want 1", dones); end
   endtask

   task automatic test_restore_conflict();
      ctx_bank = 2'd3; ctx_restore = 1'b1;
      tick();
      ctx_restore = 1'b0;
      #1;
      n_checks++; if ({si_ready, ctx_busy, so_valid} !== 3'b110) begin n_fail++; $display("[TB] FAIL restore_start got %b want 110", {si_ready, ctx_busy, so_valid}); end
      for (int w = 0; w < 4; w++) begin
         si_valid = 1'b1; si_data = 32'hB0 + w;
         we = 1'b0;
         if (w == 2) begin we = 1'b1; wr_addr = mk(0, 4'd14, 2'd0); wr_size = L; wr_data = 32'hFF; end
         if (w == 3) begin we = 1'b1; wr_addr = mk(0, 4'd0, 2'd0); wr_size = L; wr_data = 32'h12345678; end
         tick();
      end
      si_valid = 1'b0; we = 1'b0;
      #1;
      n_checks++; if ({ctx_done, ctx_busy, si_ready} !== 3'b100) begin n_fail++; $display("[TB] FAIL restore_end got %b want 100", {ctx_done, ctx_busy, si_ready}); end
      ra1 = mk(0, 4'd0, 2'd0); sz1 = L; sz0 = L;
      for (int k = 0; k < 4; k++) begin
         ra0 = mk(0, 4'(12 + k), 2'd0);
         #1;
         n_checks++; if (rd0 !== 32'hB0 + k) begin n_fail++; $display("[TB] FAIL restore_reg%0d got %h want %h", k, rd0, 32'hB0 + k); end
      end
      n_checks++; if (rd1 !== 32'h12345678) begin n_fail++; $display("[TB] FAIL restore_side_write got %h want 12345678", rd1); end
      tick();
      n_checks++; if (ctx_done !== 1'b0) begin n_fail++; $display("[TB] FAIL done_pulse_width got %b want 0", ctx_done); end
   endtask

   task automatic test_priority_freeze();
      int n = 0;
      int dones = 0;
      for (int k = 0; k < 4; k++) do_write(mk(0, 4'(k), 2'd0), L, 32'hC0 + k);
      ctx_bank = 2'd0; ctx_save = 1'b1; ctx_restore = 1'b1; so_ready = 1'b0;
      tick();
      ctx_save = 1'b0; ctx_restore = 1'b0;
      #1;
      n_checks++; if ({so_valid, si_ready} !== 2'b10) begin n_fail++; $display("[TB] FAIL save_priority got %b want 10", {so_valid, si_ready}); end
      n_checks++; if (so_data !== 32'hC0) begin n_fail++; $display("[TB] FAIL save_first_word got %h want c0", so_data); end
      ctx_save = 1'b1; ctx_bank = 2'd1;
      tick();
      ctx_save = 1'b0;
      so_ready = 1'b1;
      tick();
      cen = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         n_checks++; if ({so_valid, so_data} !== {1'b1, 32'hC1}) begin n_fail++; $display("[TB] FAIL cen_freeze cycle %0d got %b/%h want 1/c1", i, so_valid, so_data); end
      end
      cen = 1'b1;
      for (int cyc = 0; cyc < 10; cyc++) begin
         #1;
         if (so_valid && so_ready) begin
            n_checks++;
            if (n >= 3 || so_data !== 32'hC1 + n) begin n_fail++; $display("[TB] FAIL freeze_stream beat %0d got %h want %h", n, so_data, 32'hC1 + n); end
            n++;
         end
         if (ctx_done) dones++;
         tick();
      end
      n_checks++; if (n !== 3) begin n_fail++; $display("[TB] FAIL freeze_beats got %0d want 3", n); end
      n_checks++; if (dones !== 1) begin n_fail++; $display("[TB] FAIL ignored_restart_done got %0d want 1", dones); end
   endtask

   task automatic test_back_to_back();
      int k;
      so_ready = 1'b1; ctx_bank = 2'd0; ctx_save = 1'b1;
      tick();
      ctx_save = 1'b0;
      k = 1;
      #1;
      while (!ctx_done && k < 20) begin
         tick();
         k++;
      end
      n_checks++; if (k !== 5) begin n_fail++; $display("[TB] FAIL save_latency got %0d want 5", k); end
      so_ready = 1'b0;
      ctx_bank = 2'd1; ctx_restore = 1'b1;
      tick();
      ctx_restore = 1'b0;
      #1;
      n_checks++; if ({ctx_busy, si_ready} !== 2'b11) begin n_fail++; $display("[TB] FAIL restart_in_done got %b want 11", {ctx_busy, si_ready}); end
      k = 1;
      si_valid = 1'b1;
      while (!ctx_done && k < 20) begin
         si_data = 32'hD0 + (k - 1);
         tick();
         k++;
      end
      si_valid = 1'b0;
      n_checks++; if (k !== 5) begin n_fail++; $display("[TB] FAIL restore_latency got %0d want 5", k); end
      ra0 = mk(0, 4'd7, 2'd0); sz0 = L;
      #1;
      n_checks++; if (rd0 !== 32'hD3) begin n_fail++; $display("[TB] FAIL restore_bank1_last got %h want d3", rd0); end
      tick();
   endtask

   task automatic test_reset_mid();
      logic [31:0] exp_w [4];
      int n = 0;
      int dones = 0;
      exp_w[0] = 32'h0; exp_w[1] = 32'h77; exp_w[2] = 32'h0; exp_w[3] = 32'h0;
      rfp_ld = 1'b1; rfp_din = 2'd3;
      tick();
      rfp_ld = 1'b0;
      ctx_bank = 2'd1; ctx_restore = 1'b1;
      tick();
      ctx_restore = 1'b0;
      si_valid = 1'b1; si_data = 32'hE0;
      tick();
      si_data = 32'hE1;
      tick();
      si_valid = 1'b0;
      #2;
      rst_n = 1'b0;
      #1;
      ra0 = mk(0, 4'd12, 2'd0); sz0 = L;
      #1;
      n_checks++; if ({so_valid, si_ready, ctx_busy, ctx_done} !== 4'b0) begin n_fail++; $display("[TB] FAIL midreset_status got %b want 0000", {so_valid, si_ready, ctx_busy, ctx_done}); end
      n_checks++; if (rfp !== 2'd0) begin n_fail++; $display("[TB] FAIL midreset_rfp got %h want 0", rfp); end
      n_checks++; if (rd0 !== 32'd0) begin n_fail++; $display("[TB] FAIL midreset_regs got %h want 0", rd0); end
      tick();
      rst_n = 1'b1;
      tick();
      do_write(mk(0, 4'd9, 2'd0), L, 32'h77);
      ctx_bank = 2'd2; ctx_save = 1'b1; so_ready = 1'b1;
      tick();
      ctx_save = 1'b0;
      for (int cyc = 0; cyc < 10; cyc++) begin
         #1;
         if (so_valid && so_ready) begin
            n_checks++;
            if (n >= 4 || so_data !== exp_w[n % 4]) begin n_fail++; $display("[TB] FAIL post_reset_stream beat %0d got %h want %h", n, so_data, exp_w[n % 4]); end
            n++;
         end
         if (ctx_done) dones++;
         tick();
      end
      n_checks++; if (n !== 4 || dones !== 1) begin n_fail++; $display("[TB] FAIL post_reset_save got %0d beats/%0d done want 4/1", n, dones); end
   endtask

   initial begin
      rst_n = 1'b0; cen = 1'b1;
      rfp_ld = 1'b0; rfp_din = '0;
      ra0 = '0; ra1 = '0; sz0 = L; sz1 = L;
      we = 1'b0; wr_addr = '0; wr_size = L; wr_data = '0;
      ctx_save = 1'b0; ctx_restore = 1'b0; ctx_bank = '0;
      so_ready = 1'b0; si_valid = 1'b0; si_data = '0;
      repeat (3) tick();
      rst_n = 1'b1;
      tick();
      test_reset();
      test_lanes();
      test_bank_switch();
      test_save_toggle();
      test_restore_conflict();
      test_priority_freeze();
      test_back_to_back();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/jt900h_bankrf.md
# jt900h_bankrf

Parametrised banked register file for the JT900H core, successor to the fixed 4-bank/16-accumulator file. Holds `BANKS` banks of `REGS` general registers plus `PTRS` global pointer registers, with `RDP` independent read ports and one sized write port. Adds a context engine that streams any bank out to, or back in from, an external agent over valid/ready handshakes. The interrupt/bank-switch logic uses this engine for register save and restore.

## Interface
- `DW`, 32: register width; must be 32.
- `BANKS`, 4: number of banks; power of 2, ≥2.
- `REGS`, 4: general registers per bank; power of 2.
- `PTRS`, 4: global pointer registers; power of 2.
- `RDP`, 2: number of read ports.
- `AW`, derived as 1+clog2(BANKS*REGS)+2: register address width, `{ptr, index, lane[1:0]}`.

Ports:
- `clk` in 1: clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `cen` in 1: clock enable; all state advances only when high.
- `rfp` out clog2(BANKS): current bank pointer.
- `rfp_ld` in 1: load `rfp` from `rfp_din`.
- `rfp_din` in clog2(BANKS): new bank.
- `rd_addr` in RDP*AW: read addresses. Index is relative to the current bank when `ptr`=0; when `ptr`=1 the low clog2(PTRS) index bits select a pointer.
- `rd_size` in RDP*2: 0 byte, 1 word, 2 long.
- `rd_data` out RDP*DW: zero-extended read data.
- `we`, `wr_addr` (AW), `wr_size` (2), `wr_data` (DW) in: write port, same addressing.
- `ctx_save`, `ctx_restore` in 1: start pulses.
- `ctx_bank` in clog2(BANKS): target bank; sampled at start.
- `so_valid` out 1, `so_ready` in 1, `so_data` out DW: save stream.
- `si_valid` in 1, `si_ready` out 1, `si_data` in DW: restore stream.
- `ctx_busy` out 1, `ctx_done` out 1: engine status; `ctx_done` is a one-`cen`-cycle pulse.

## Operation
- Read path is combinational. The lane selects the byte (any lane) or the word (lane[1]). Long reads ignore the lane.
- Writes update only the addressed byte/word/long.
- `rfp_ld` takes effect on the next cycle. Reads in the same cycle use the old `rfp`.
- Context FSM states: IDLE, SAVE, RESTORE.
- IDLE → SAVE on `ctx_save`. IDLE → RESTORE on `ctx_restore`. If both are asserted, SAVE wins.
- Start pulses while `ctx_busy` are ignored.
- Starting latches `ctx_bank` and clears the index counter `idx`.
- SAVE:
  - `so_data` is a registered copy of `regs[bank][idx]`.
  - `so_valid` is held until `so_ready`. Each handshake advances `idx`.
  - After the handshake at `idx`=REGS-1 → IDLE, with `ctx_done` asserted.
  - Values are live. A core write landing in the same cycle as the load of `so_data` is not reflected in that word.
- RESTORE:
  - `si_ready`=1. Each `si_valid&si_ready` writes `si_data` into `regs[bank][idx]`, long size, and advances `idx`.
  - The last word → IDLE, with `ctx_done` asserted.
  - A same-cycle core write to the same register is dropped; restore wins. Writes to other registers proceed.
- `ctx_bank` may equal `rfp`; no special handling.
- `cen` low freezes the FSM, `idx`, `so_valid`/`so_data` and `si_ready`. Handshakes only count when `cen` is high.

## Timing
- Reset values: all registers 0, `rfp`=0, `so_valid`=0, `so_data`=0, `si_ready`=0, `ctx_busy`=0, `ctx_done`=0, FSM=IDLE.
- Reset mid-operation aborts the transfer with no partial-state guarantee beyond the zero reset.
- Read latency: 0 cycles. Write visible on reads in the cycle after `we`.
- SAVE:
  - `ctx_busy` and `so_valid` are high from the cycle after start.
  - With `so_ready` tied high, a save takes REGS+1 cycles from start to `ctx_done`.
- RESTORE:
  - `si_ready` rises the cycle after start.
  - With `si_valid` high, a restore takes REGS+1 cycles.
- `ctx_done` is asserted in the cycle after the final handshake, while `ctx_busy` falls.
- A new start is accepted in that same cycle.

## Structure
- Package `jt900h_bankrf_pkg` holds:
  - size encodings: SZ_B, SZ_W, SZ_L;
  - FSM state enum: CTX_IDLE, CTX_SAVE, CTX_RESTORE.
- Sub-module `jt900h_bankrf_ctx` holds the FSM, index counter and handshake logic. It drives a restore write strobe and index into the parent array.
- The parent owns storage, the read muxes and write arbitration.

## Test plan
- Reset, then long write 0x11223344 to bank0 reg1. Byte read at lane 2 → 0x22; word read at lane 2 → 0x1122; long read → 0x11223344.
- Write reg0 in banks 0 and 1 with different values, pulse `rfp_ld`=1. The same address reads the bank-1 value the next cycle; pointer reads are unchanged.
- Fill bank 2 with 0xA0..0xA3 and save with `so_ready` toggling 1,0,1,…. The stream is 0xA0,0xA1,0xA2,0xA3 in order, with no duplicates, and `ctx_done` pulses exactly once.
- Restore bank 3 from 0xB0..0xB3 while the core writes 0xFF to bank3 reg2 in the same cycle as word 2. Result: reg2=0xB2, and a concurrent write to bank0 reg0 succeeds.
- Pulse `ctx_save` and `ctx_restore` together → SAVE runs. A second `ctx_save` mid-save is ignored. Holding `cen` low for 3 cycles mid-save keeps `so_valid`/`so_data` stable.
- Drop `rst_n` during RESTORE → all outputs return to reset values immediately. After release, a new save proceeds normally.
